// File: rtl/cmp_pkg.sv
// Shared types and result-selection helper for the sequential operand comparator.
package cmp_pkg;

  typedef enum logic [2:0] {
    CmpEq  = 3'd0,
    CmpNe  = 3'd1,
    CmpLt  = 3'd2,
    CmpLtu = 3'd3,
    CmpGe  = 3'd4,
    CmpGeu = 3'd5
  } cmp_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } cmp_state_t;

  typedef struct packed {
    logic eq;
    logic neq;
    logic lt;
    logic ltu;
    logic res;
  } cmp_result_t;

  // Codes 6 and 7 are reserved and always select 0.
  function automatic logic mode_select(input logic [2:0] mode, input logic eq, input logic lt,
                                       input logic ltu);
    logic r;
    r = 1'b0;
    case (mode)
      CmpEq:   r = eq;
      CmpNe:   r = ~eq;
      CmpLt:   r = lt;
      CmpLtu:  r = ltu;
      CmpGe:   r = ~lt;
      CmpGeu:  r = ~ltu;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/equality_check.sv
// Combinational N-bit equality detector.
module equality_check #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         eq_o
);

  assign eq_o = ~|(a_i ^ b_i);

endmodule

// File: rtl/seq_compare_unit.sv
// Multi-cycle chunked comparator: walks W-bit chunks MSB first and stops at the first
// differing chunk, producing eq/neq/lt/ltu and a mode-selected result.
module seq_compare_unit
  import cmp_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         eq,
  output logic         neq,
  output logic         lt,
  output logic         ltu,
  output logic         res
);

  localparam int unsigned WSafe  = (W < 1) ? 1 : W;
  localparam int unsigned NCHUNK = N / WSafe;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(NCHUNK - 1);

  if ((W < 1) || ((N % WSafe) != 0)) begin : gen_param_check
    $fatal(1, "seq_compare_unit: W must be >= 1 and divide N");
  end

  cmp_state_t                   state_q, state_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  cmp_result_t                  res_q, res_d;
  logic [NCHUNK-1:0][WSafe-1:0] a_q, b_q;
  logic [2:0]                   mode_q;
  logic                         load;

  logic [WSafe-1:0] a_chunk, b_chunk;
  logic [WSafe-1:0] a_view, b_view;
  logic             is_top, chunk_eq, chunk_lt, chunk_ltu;

  if (NCHUNK == 1) begin : gen_single
    assign a_chunk = a_q[0];
    assign b_chunk = b_q[0];
  end else begin : gen_multi
    assign a_chunk = a_q[idx_q];
    assign b_chunk = b_q[idx_q];
  end

  equality_check #(
    .N(WSafe)
  ) u_chunk_eq (
    .a_i (a_chunk),
    .b_i (b_chunk),
    .eq_o(chunk_eq)
  );

  // Flipping the sign bit maps two's complement onto unsigned order for the top chunk.
  always_comb begin
    is_top = (idx_q == IdxTop);
    a_view = a_chunk;
    b_view = b_chunk;
    a_view[WSafe-1] = a_chunk[WSafe-1] ^ is_top;
    b_view[WSafe-1] = b_chunk[WSafe-1] ^ is_top;
    chunk_lt  = (a_view < b_view);
    chunk_ltu = (a_chunk < b_chunk);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    res_d   = res_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          idx_d   = IdxTop;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!chunk_eq) begin
          res_d.eq  = 1'b0;
          res_d.neq = 1'b1;
          res_d.lt  = chunk_lt;
          res_d.ltu = chunk_ltu;
          res_d.res = mode_select(mode_q, 1'b0, chunk_lt, chunk_ltu);
          state_d   = StDone;
        end else if (idx_q == '0) begin
          res_d.eq  = 1'b1;
          res_d.neq = 1'b0;
          res_d.lt  = 1'b0;
          res_d.ltu = 1'b0;
          res_d.res = mode_select(mode_q, 1'b1, 1'b0, 1'b0);
          state_d   = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= IdxTop;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  // Operand latches need no reset: they are only read after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q    <= a;
      b_q    <= b;
      mode_q <= mode;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign eq        = res_q.eq;
  assign neq       = res_q.neq;
  assign lt        = res_q.lt;
  assign ltu       = res_q.ltu;
  assign res       = res_q.res;

  a_neq_complement : assert property (@(posedge clk) disable iff (reset)
    out_valid |-> (neq == ~eq));

endmodule

// File: tb/tb_seq_compare_unit.sv
// Bench for seq_compare_unit: three builds (W=8, W=1, W=N) driven in lockstep and checked
// against an arithmetic reference model.
module tb_seq_compare_unit;

  localparam int unsigned N = 32;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] a, b;
  logic [2:0]  mode;
  logic [2:0]  in_ready_v, out_valid_v, eq_v, neq_v, lt_v, ltu_v, res_v;

  int n_checks = 0;
  int n_errors = 0;

  seq_compare_unit #(.N(N), .W(8)) u_dut_w8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[0]), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid_v[0]), .out_ready(out_ready), .eq(eq_v[0]),
    .neq(neq_v[0]), .lt(lt_v[0]), .ltu(ltu_v[0]), .res(res_v[0])
  );

  seq_compare_unit #(.N(N), .W(1)) u_dut_w1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[1]), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid_v[1]), .out_ready(out_ready), .eq(eq_v[1]),
    .neq(neq_v[1]), .lt(lt_v[1]), .ltu(ltu_v[1]), .res(res_v[1])
  );

  seq_compare_unit #(.N(N), .W(N)) u_dut_wn (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_v[2]), .a(a), .b(b),
    .mode(mode), .out_valid(out_valid_v[2]), .out_ready(out_ready), .eq(eq_v[2]),
    .neq(neq_v[2]), .lt(lt_v[2]), .ltu(ltu_v[2]), .res(res_v[2])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int d);
    case (d)
      0:       return 8;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Chunks examined = distance from the top chunk to the highest differing chunk, plus one.
  function automatic int exp_latency(input logic [31:0] x, input logic [31:0] y, input int w);
    int          n;
    logic [63:0] diff, mask;
    n    = 32 / w;
    diff = {32'b0, x ^ y};
    mask = (64'd1 << w) - 64'd1;
    for (int c = n - 1; c >= 0; c--) begin
      if (((diff >> (c * w)) & mask) != 64'd0) return n - c;
    end
    return n;
  endfunction

  function automatic logic exp_res(input logic [2:0] m, input logic e, input logic l,
                                   input logic lu);
    case (m)
      3'd0:    return e;
      3'd1:    return !e;
      3'd2:    return l;
      3'd3:    return lu;
      3'd4:    return !l;
      3'd5:    return !lu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_compare(input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic [2:0] tm, input int hold, input string name);
    int          lat[3];
    int          cyc;
    logic        e_eq, e_lt, e_ltu, e_res;
    logic [14:0] e_vec;
    e_eq  = (ta == tb_v);
    e_lt  = ($signed(ta) < $signed(tb_v));
    e_ltu = (ta < tb_v);
    e_res = exp_res(tm, e_eq, e_lt, e_ltu);
    e_vec = {{3{e_eq}}, {3{!e_eq}}, {3{e_lt}}, {3{e_ltu}}, {3{e_res}}};

    @(posedge clk); #1;
    check({name, " in_ready before accept"}, in_ready_v, 3'b111);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    mode = tm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    mode = 3'($urandom);
    check({name, " in_ready after accept"}, in_ready_v, 3'b000);

    lat = '{0, 0, 0};
    cyc = 0;
    while (cyc < 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
      @(posedge clk); #1;
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (out_valid_v[d] && lat[d] == 0) lat[d] = cyc;
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s latency W=%0d", name, width_of(d)), lat[d],
            exp_latency(ta, tb_v, width_of(d)));
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check($sformatf("%s hold cycle %0d", name, h), {out_valid_v, in_ready_v, eq_v, neq_v,
            lt_v, ltu_v, res_v}, {3'b111, 3'b000, e_vec});
    end

    check({name, " out_valid"}, out_valid_v, 3'b111);
    check({name, " results eq,neq,lt,ltu,res"}, {eq_v, neq_v, lt_v, ltu_v, res_v}, e_vec);

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " handoff valid/ready"}, {out_valid_v, in_ready_v}, {3'b000, 3'b111});
    check({name, " results kept in idle"}, {eq_v, neq_v, lt_v, ltu_v, res_v}, e_vec);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    mode      = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset state valid/ready", {out_valid_v, in_ready_v}, {3'b000, 3'b111});
    check("reset state results", {eq_v, neq_v, lt_v, ltu_v, res_v}, 15'd0);

    // Reset mid-compare abandons it.
    @(posedge clk); #1;
    in_valid = 1'b1;
    a = 32'd1;
    b = 32'd1;
    mode = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("abandon valid/ready", {out_valid_v, in_ready_v}, {3'b000, 3'b111});
    check("abandon results", {eq_v, neq_v, lt_v, ltu_v, res_v}, 15'd0);

    run_compare(32'hDEADBEEF, 32'hDEADBEEF, 3'd0, 0, "eq deadbeef");
    run_compare(32'h80000000, 32'h00000001, 3'd2, 0, "lt signed");
    run_compare(32'h80000000, 32'h00000001, 3'd5, 0, "geu");
    run_compare(32'h12345600, 32'h12345601, 3'd3, 0, "ltu low chunk");
    run_compare(32'h12345600, 32'h12345601, 3'd4, 5, "ge held result");

    for (int i = 0; i < 32; i++) begin
      run_compare(32'd1 << i, 32'd1 << i, 3'($urandom_range(0, 7)), 0,
                  $sformatf("walk eq %0d", i));
      run_compare(32'd1 << i, 32'd0, 3'($urandom_range(0, 7)), 0,
                  $sformatf("walk a %0d", i));
      run_compare(32'd0, 32'd1 << i, 3'($urandom_range(0, 7)), 0,
                  $sformatf("walk b %0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = ra;
        2:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = {ra[31:8], 8'($urandom)};
      endcase
      run_compare(ra, rb, 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                  $sformatf("random %0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
